// File: rtl/tube_host_if.sv
// Host-side Tube register bus: decode inputs, status/select outputs and control flag exports.
// The master side is the host bus plus datapath view; the slave side is tube_host_ctrl.
interface tube_host_if;
   logic       h_cs_b;
   logic       h_rdnw;
   logic [2:0] h_addr;
   logic [7:0] h_din;
   logic [3:0] h_data_available;
   logic [3:0] h_not_full;
   logic [7:0] h_dout;
   logic       h_status_oe;
   logic [3:0] h_select;
   logic       h_rd;
   logic [6:0] ctrl_flags;
   logic       fifo_clr;
   logic       h_irq_b;
   logic       p_rst_b;

   modport master (
      output h_cs_b, h_rdnw, h_addr, h_din, h_data_available, h_not_full,
      input  h_dout, h_status_oe, h_select, h_rd, ctrl_flags, fifo_clr, h_irq_b, p_rst_b
   );

   modport slave (
      input  h_cs_b, h_rdnw, h_addr, h_din, h_data_available, h_not_full,
      output h_dout, h_status_oe, h_select, h_rd, ctrl_flags, fifo_clr, h_irq_b, p_rst_b
   );
endinterface

// File: rtl/tube_host_ctrl.sv
// Tube host register controller: address decode, status bytes, {T,P,V,M,J,I,Q} flags, IRQ, clear pulse.
// TUBE_SOFT_RESET_EN adds the P-flag countdown that times p_rst_b; otherwise p_rst_b follows h_rst_b.
module tube_host_ctrl #(
   parameter int unsigned RST_CYCLES = 8
) (
   input  logic        h_phi2,
   input  logic        h_rst_b,
   tube_host_if.slave  hif
);

   if (RST_CYCLES < 1 || RST_CYCLES > 255) begin : g_bad_rst_cycles
      $error("RST_CYCLES must be in 1..255");
   end

   logic [1:0] chan;
   logic [5:0] low6;
   logic       ctrl_wr;
   logic [6:0] flags_q, flags_d;

   assign chan    = hif.h_addr[2:1];
   assign ctrl_wr = !hif.h_cs_b && !hif.h_rdnw && (hif.h_addr == 3'd0);

   assign hif.h_select    = (!hif.h_cs_b && hif.h_addr[0]) ? (4'b0001 << chan) : 4'b0000;
   assign hif.h_status_oe = !hif.h_cs_b && hif.h_rdnw && !hif.h_addr[0];
   assign hif.h_rd        = !hif.h_cs_b && hif.h_rdnw;

   // Only R1 status carries the flags; the other channels pad with ones.
   assign low6       = (chan == 2'd0) ? flags_q[5:0] : 6'h3f;
   assign hif.h_dout = {hif.h_data_available[chan], hif.h_not_full[chan], low6};

   assign hif.ctrl_flags = flags_q;
   assign hif.fifo_clr   = flags_q[6];
   assign hif.h_irq_b    = !(flags_q[0] && hif.h_data_available[3]);

`ifdef TUBE_SOFT_RESET_EN
   localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_q != 8'd0) begin
         cnt_d = cnt_q - 8'd1;
      end
      // Any write touching P either reloads (set) or aborts (clear) the countdown.
      if (ctrl_wr && hif.h_din[5]) begin
         cnt_d = hif.h_din[7] ? RST_LOAD : 8'd0;
      end
   end

   always_ff @(negedge h_phi2 or negedge h_rst_b) begin
      if (!h_rst_b) begin
         cnt_q <= RST_LOAD;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign hif.p_rst_b = (cnt_q == 8'd0);
`else
   assign hif.p_rst_b = h_rst_b;
`endif

   always_comb begin
      flags_d    = flags_q;
      flags_d[6] = 1'b0;
`ifdef TUBE_SOFT_RESET_EN
      if (cnt_q == 8'd1) begin
         flags_d[5] = 1'b0;
      end
`endif
      if (ctrl_wr) begin
         if (hif.h_din[7]) begin
            flags_d = flags_d | hif.h_din[6:0];
         end else begin
            flags_d = flags_d & ~hif.h_din[6:0];
         end
      end
   end

   always_ff @(negedge h_phi2 or negedge h_rst_b) begin
      if (!h_rst_b) begin
         flags_q <= 7'd0;
      end else begin
         flags_q <= flags_d;
      end
   end

endmodule

// File: tb/tb_tube_host_ctrl.sv
// Bench for tube_host_ctrl: directed literal checks plus randomized traffic against a cycle model.
module tb_tube_host_ctrl;
   localparam int RST = 8;

   logic h_phi2;
   logic h_rst_b;
   tube_host_if hif();

   tube_host_ctrl #(.RST_CYCLES(RST)) dut (
      .h_phi2  (h_phi2),
      .h_rst_b (h_rst_b),
      .hif     (hif)
   );

   int chk_cnt = 0;
   int err_cnt = 0;
   bit chk_en  = 0;

   initial h_phi2 = 1'b1;
   always #5 h_phi2 = ~h_phi2;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Model: flag bits plus the number of cycles the parasite reset has left to run.
   logic [6:0] m_flags;
   int         m_low;
   bit         m_wr;

   always @(negedge h_phi2 or negedge h_rst_b) begin
      if (!h_rst_b) begin
         m_flags = 7'd0;
`ifdef TUBE_SOFT_RESET_EN
         m_low = RST;
`else
         m_low = 0;
`endif
      end else begin
         m_wr = !hif.h_cs_b && !hif.h_rdnw && (hif.h_addr == 3'd0);
         m_flags[6] = 1'b0;
         if (m_low > 0) begin
            m_low = m_low - 1;
            if (m_low == 0) m_flags[5] = 1'b0;
         end
         if (m_wr) begin
            if (hif.h_din[7]) m_flags = m_flags | hif.h_din[6:0];
            else              m_flags = m_flags & ~hif.h_din[6:0];
`ifdef TUBE_SOFT_RESET_EN
            if (hif.h_din[5]) m_low = hif.h_din[7] ? RST : 0;
`endif
         end
      end
   end

   int         e_ch;
   logic [3:0] e_sel;
   logic [7:0] e_dout;

   always @(posedge h_phi2) begin
      if (chk_en) begin
         e_ch   = int'(hif.h_addr) / 2;
         e_sel  = (!hif.h_cs_b && (hif.h_addr % 2 == 1)) ? 4'(1 << e_ch) : 4'd0;
         e_dout = {hif.h_data_available[e_ch], hif.h_not_full[e_ch],
                   (e_ch == 0) ? m_flags[5:0] : 6'h3f};
         check("select", 32'(hif.h_select), 32'(e_sel));
         check("status_oe", 32'(hif.h_status_oe), 32'(!hif.h_cs_b && hif.h_rdnw && (hif.h_addr % 2 == 0)));
         check("h_rd", 32'(hif.h_rd), 32'(!hif.h_cs_b && hif.h_rdnw));
         check("dout", 32'(hif.h_dout), 32'(e_dout));
         check("ctrl_flags", 32'(hif.ctrl_flags), 32'(m_flags));
         check("fifo_clr", 32'(hif.fifo_clr), 32'(m_flags[6]));
         check("irq_b", 32'(hif.h_irq_b), 32'(!(m_flags[0] && hif.h_data_available[3])));
         check("p_rst_b", 32'(hif.p_rst_b), 32'(h_rst_b && (m_low == 0)));
      end
   end

   task automatic tick();
      @(negedge h_phi2);
      #2;
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      hif.h_cs_b = 1'b0;
      hif.h_rdnw = 1'b0;
      hif.h_addr = a;
      hif.h_din  = d;
      tick();
      hif.h_cs_b = 1'b1;
      hif.h_rdnw = 1'b1;
   endtask

   task automatic wait_prst(output int n);
      n = 0;
      while (hif.p_rst_b !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      err_cnt++;
      $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
      $fatal(1);
   end

   initial begin
      int n;
      int total;
      h_rst_b = 1'b1;
      hif.h_cs_b = 1'b1;
      hif.h_rdnw = 1'b1;
      hif.h_addr = 3'd0;
      hif.h_din  = 8'd0;
      hif.h_data_available = 4'd0;
      hif.h_not_full = 4'd0;
      #3 h_rst_b = 1'b0;
      #1 chk_en = 1;
      tick();
      tick();
      #1;
      check("rst_p_rst_b", 32'(hif.p_rst_b), 32'd0);
      check("rst_flags", 32'(hif.ctrl_flags), 32'd0);
      check("rst_fifo_clr", 32'(hif.fifo_clr), 32'd0);
      check("rst_irq_b", 32'(hif.h_irq_b), 32'd1);

      hif.h_data_available = 4'b0001;
      hif.h_not_full = 4'b1111;
      hif.h_cs_b = 1'b0;
      hif.h_rdnw = 1'b1;
      hif.h_addr = 3'd0;
      #1;
      check("status_r1", 32'(hif.h_dout), 32'hC0);
      check("status_oe_r1", 32'(hif.h_status_oe), 32'd1);
      h_rst_b = 1'b1;
      wait_prst(n);
`ifdef TUBE_SOFT_RESET_EN
      check("release_cycles", 32'(n), 32'(RST));
`else
      check("release_cycles", 32'(n), 32'd0);
`endif
      check("release_irq_b", 32'(hif.h_irq_b), 32'd1);

      hif.h_data_available = 4'b1000;
      wr(3'd0, 8'h81);
      #1;
      check("q_set_flags", 32'(hif.ctrl_flags), 32'h01);
      check("q_set_irq", 32'(hif.h_irq_b), 32'd0);
      wr(3'd0, 8'h01);
      #1;
      check("q_clr_irq", 32'(hif.h_irq_b), 32'd1);

      wr(3'd0, 8'hC0);
      #1;
      check("t_pulse_hi", 32'(hif.fifo_clr), 32'd1);
      check("t_flag_hi", 32'(hif.ctrl_flags[6]), 32'd1);
      tick();
      #1;
      check("t_pulse_lo", 32'(hif.fifo_clr), 32'd0);
      check("t_flag_lo", 32'(hif.ctrl_flags[6]), 32'd0);

`ifdef TUBE_SOFT_RESET_EN
      wr(3'd0, 8'hA0);
      #1;
      check("p_set_low", 32'(hif.p_rst_b), 32'd0);
      wait_prst(n);
      check("p_low_cycles", 32'(n), 32'(RST));
      check("p_selfclear", 32'(hif.ctrl_flags[5]), 32'd0);

      wr(3'd0, 8'hA0);
      tick(); tick(); tick();
      wr(3'd0, 8'hA0);
      wait_prst(n);
      total = 4 + n;
      check("p_reload_total", 32'(total), 32'd12);

      wr(3'd0, 8'hA0);
      tick(); tick();
      wr(3'd0, 8'h20);
      #1;
      check("p_abort_high", 32'(hif.p_rst_b), 32'd1);
      check("p_abort_flag", 32'(hif.ctrl_flags[5]), 32'd0);
`else
      wr(3'd0, 8'hA0);
      for (int i = 0; i < 10; i++) tick();
      #1;
      check("p_plain_flag", 32'(hif.ctrl_flags[5]), 32'd1);
      check("p_plain_rst", 32'(hif.p_rst_b), 32'd1);
      wr(3'd0, 8'h20);
`endif

      for (int i = 0; i < 4; i++) begin
         hif.h_cs_b = 1'b0;
         hif.h_rdnw = 1'b1;
         hif.h_addr = 3'(2 * i + 1);
         #1;
         check("sel_onehot", 32'(hif.h_select), 32'(1 << i));
         check("sel_no_oe", 32'(hif.h_status_oe), 32'd0);
         hif.h_cs_b = 1'b1;
         #1;
         check("sel_cs_off", 32'(hif.h_select), 32'd0);
         check("oe_cs_off", 32'(hif.h_status_oe), 32'd0);
         tick();
      end

      total = 0;
      tick();
      h_rst_b = 1'b0;
      #1;
      check("hard_rst_prst", 32'(hif.p_rst_b), 32'd0);
      check("hard_rst_flags", 32'(hif.ctrl_flags), 32'd0);
      tick();
      h_rst_b = 1'b1;
`ifdef TUBE_SOFT_RESET_EN
      tick(); tick(); tick();
      h_rst_b = 1'b0;
      tick();
      h_rst_b = 1'b1;
      wait_prst(n);
      check("hard_rst_restart", 32'(n), 32'(RST));
`else
      #1;
      check("hard_rst_follow", 32'(hif.p_rst_b), 32'd1);
`endif

      for (int k = 0; k < 2000; k++) begin
         hif.h_cs_b = ($urandom % 4) == 0;
         hif.h_rdnw = 1'($urandom);
         hif.h_addr = ($urandom % 2 == 0) ? 3'd0 : 3'($urandom);
         hif.h_din  = 8'($urandom);
         hif.h_data_available = 4'($urandom);
         hif.h_not_full = 4'($urandom);
         tick();
      end

      chk_en = 0;
      $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
      $finish;
   end
endmodule
